// File: rtl/ct_mat_pkg.sv
// Shared types and constants for the matrix completion path.
// Source ids double as round-robin pointer values.
package ct_mat_pkg;

  localparam int MAT_IID_W = 7;
  localparam int MAT_CMPLT_SRC_NUM = 3;

  typedef enum logic [1:0] {
    MAT_SRC_CFG = 2'd0,
    MAT_SRC_ALU = 2'd1,
    MAT_SRC_LSU = 2'd2
  } mat_cmplt_src_e;

endpackage

// File: rtl/ct_mat_cmplt_fifo.sv
// Per-source completion FIFO with conservative credit ready.
// A push while not ready is dropped; flush empties it next cycle.
module ct_mat_cmplt_fifo #(
  parameter int DEPTH = 2,
  parameter int IID_W = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stor_en,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [IID_W-1:0]           din,
  output logic [IID_W-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       rdy,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IID_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign rdy     = cnt < CW'(DEPTH);
  assign empty   = cnt == '0;
  assign count   = cnt;
  assign head    = mem[rptr];
  assign push_ok = push & rdy & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;

  // Pointers and occupancy, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok)
        wptr <= wptr + PW'(1);
      if (pop_ok)
        rptr <= rptr + PW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Entry storage, written only while the storage enable is on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (push_ok && stor_en) begin
      mem[wptr] <= din;
    end
  end

endmodule

// File: rtl/ct_mat_cmplt_arb.sv
// Round-robin completion arbiter for cfg/alu/lsu onto pipe8.
// CT_MAT_CMPLT_BYPASS_EN lets an empty source complete same-cycle.
module ct_mat_cmplt_arb
  import ct_mat_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IID_W = MAT_IID_W
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             cp0_mat_icg_en,
  input  logic             cp0_yy_clk_en,
  input  logic             pad_yy_icg_scan_en,
  input  logic             rtu_yy_xx_flush,
  input  logic             mat_cfg_cbus_ex1_pipe8_sel,
  input  logic [IID_W-1:0] mat_cfg_cbus_ex1_pipe8_iid,
  input  logic             mat_alu_cbus_ex1_pipe8_sel,
  input  logic [IID_W-1:0] mat_alu_cbus_ex1_pipe8_iid,
  input  logic             mat_lsu_cbus_ex1_pipe8_sel,
  input  logic [IID_W-1:0] mat_lsu_cbus_ex1_pipe8_iid,
  output logic             mat_cmplt_cfg_rdy,
  output logic             mat_cmplt_alu_rdy,
  output logic             mat_cmplt_lsu_rdy,
  output logic             mat_rtu_pipe8_cmplt,
  output logic [IID_W-1:0] mat_rtu_pipe8_iid,
  output logic             mat_cmplt_idle
);

  localparam int N  = MAT_CMPLT_SRC_NUM;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N-1:0]     sel;
  logic [N-1:0]     push;
  logic [N-1:0]     pop;
  logic [N-1:0]     rdy;
  logic [N-1:0]     empty;
  logic [N-1:0]     byp;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [N-1:0]     busy;
  logic [IID_W-1:0] din  [N];
  logic [IID_W-1:0] head [N];
  logic [CW-1:0]    cnt  [N];
  logic             flush;
  logic             stor_en;
  mat_cmplt_src_e   rr;
  mat_cmplt_src_e   rr_nxt;

  assign flush  = rtu_yy_xx_flush;
  assign sel    = {mat_lsu_cbus_ex1_pipe8_sel,
                   mat_alu_cbus_ex1_pipe8_sel,
                   mat_cfg_cbus_ex1_pipe8_sel};
  assign din[0] = mat_cfg_cbus_ex1_pipe8_iid;
  assign din[1] = mat_alu_cbus_ex1_pipe8_iid;
  assign din[2] = mat_lsu_cbus_ex1_pipe8_iid;

  for (genvar i = 0; i < N; i++) begin : g_busy
    assign busy[i] = cnt[i] != '0;
  end

  assign stor_en = pad_yy_icg_scan_en
                 | (cp0_yy_clk_en
                    & (cp0_mat_icg_en | (|sel) | (|busy)));

`ifdef CT_MAT_CMPLT_BYPASS_EN
  assign byp = sel & empty & {N{~flush}};
`else
  assign byp = '0;
`endif

  assign req  = (~empty | byp) & {N{~flush}};
  assign pop  = gnt & ~empty;
  assign push = sel & {N{~flush}} & ~(gnt & byp);

  for (genvar i = 0; i < N; i++) begin : g_fifo
    ct_mat_cmplt_fifo #(
      .DEPTH (DEPTH),
      .IID_W (IID_W)
    ) u_fifo (
      .clk     (forever_cpuclk),
      .rst_n   (cpurst_b),
      .stor_en (stor_en),
      .push    (push[i]),
      .pop     (pop[i]),
      .flush   (flush),
      .din     (din[i]),
      .head    (head[i]),
      .count   (cnt[i]),
      .rdy     (rdy[i]),
      .empty   (empty[i])
    );
  end

  // Grant the first requester searching from rr upward.
  always_comb begin
    gnt = '0;
    unique case (rr)
      MAT_SRC_CFG: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
      MAT_SRC_ALU: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      MAT_SRC_LSU: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: gnt = '0;
    endcase
  end

  // Pointer moves past the granted source; flush restarts at cfg.
  always_comb begin
    rr_nxt = rr;
    if (flush)
      rr_nxt = MAT_SRC_CFG;
    else
      unique case (1'b1)
        gnt[0]:  rr_nxt = MAT_SRC_ALU;
        gnt[1]:  rr_nxt = MAT_SRC_LSU;
        gnt[2]:  rr_nxt = MAT_SRC_CFG;
        default: rr_nxt = rr;
      endcase
  end

  // Round-robin pointer register.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)
      rr <= MAT_SRC_CFG;
    else
      rr <= rr_nxt;
  end

  // Retire the granted head, or the bypassed input IID.
  always_comb begin
    mat_rtu_pipe8_iid = '0;
    unique case (1'b1)
      gnt[0]:  mat_rtu_pipe8_iid = byp[0] ? din[0] : head[0];
      gnt[1]:  mat_rtu_pipe8_iid = byp[1] ? din[1] : head[1];
      gnt[2]:  mat_rtu_pipe8_iid = byp[2] ? din[2] : head[2];
      default: mat_rtu_pipe8_iid = '0;
    endcase
  end

  assign mat_rtu_pipe8_cmplt = |gnt;
  assign mat_cmplt_cfg_rdy   = rdy[0];
  assign mat_cmplt_alu_rdy   = rdy[1];
  assign mat_cmplt_lsu_rdy   = rdy[2];
  assign mat_cmplt_idle      = &empty;

endmodule

// File: tb/tb_ct_mat_cmplt_arb.sv
// Bench for ct_mat_cmplt_arb: vector table, corner sequences
// and a queue-based reference model under random traffic.
module tb_ct_mat_cmplt_arb;

  localparam int DEPTH = 2;
`ifdef CT_MAT_CMPLT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       cfg_sel, alu_sel, lsu_sel;
  logic [6:0] cfg_iid, alu_iid, lsu_iid;
  logic       cfg_rdy, alu_rdy, lsu_rdy;
  logic       cmplt;
  logic [6:0] iid;
  logic       idle;

  int total = 0;
  int bad   = 0;

  logic [6:0] mq [3][$];
  int         mrr;

  logic       e_cmplt;
  logic [6:0] e_iid;
  logic [2:0] e_rdy;
  logic       e_idle;
  logic       o_cmplt;
  logic [6:0] o_iid;
  logic [2:0] o_rdy;
  logic       o_idle;

  typedef struct {
    logic [2:0] sel;
    logic [6:0] i0, i1, i2;
    logic       c;
    logic [6:0] id;
    logic [2:0] r;
    logic       idl;
  } vec_t;

  vec_t vt [10];

  always #5 clk = ~clk;

  ct_mat_cmplt_arb #(.DEPTH(DEPTH), .IID_W(7)) dut (
    .forever_cpuclk             (clk),
    .cpurst_b                   (rst_n),
    .cp0_mat_icg_en             (1'b0),
    .cp0_yy_clk_en              (1'b1),
    .pad_yy_icg_scan_en         (1'b0),
    .rtu_yy_xx_flush            (flush),
    .mat_cfg_cbus_ex1_pipe8_sel (cfg_sel),
    .mat_cfg_cbus_ex1_pipe8_iid (cfg_iid),
    .mat_alu_cbus_ex1_pipe8_sel (alu_sel),
    .mat_alu_cbus_ex1_pipe8_iid (alu_iid),
    .mat_lsu_cbus_ex1_pipe8_sel (lsu_sel),
    .mat_lsu_cbus_ex1_pipe8_iid (lsu_iid),
    .mat_cmplt_cfg_rdy          (cfg_rdy),
    .mat_cmplt_alu_rdy          (alu_rdy),
    .mat_cmplt_lsu_rdy          (lsu_rdy),
    .mat_rtu_pipe8_cmplt        (cmplt),
    .mat_rtu_pipe8_iid          (iid),
    .mat_cmplt_idle             (idle)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] s,
                              input logic [6:0] a, b, c,
                              input logic ec,
                              input logic [6:0] ei,
                              input logic [2:0] er,
                              input logic ed);
    vec_t v;
    v.sel = s; v.i0 = a; v.i1 = b; v.i2 = c;
    v.c = ec; v.id = ei; v.r = er; v.idl = ed;
    return v;
  endfunction

  function automatic bit mrdy(input int i);
    return mq[i].size() < DEPTH;
  endfunction

  // Spec-level model: FIFO queues and a modulo-3 search.
  task automatic model_eval(input logic [2:0] s,
                            input logic [6:0] a, b, c,
                            input logic f);
    logic [6:0] iin [3];
    bit         acc [3];
    int         g;
    int         idx;
    iin[0] = a; iin[1] = b; iin[2] = c;
    e_idle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e_rdy[i] = mrdy(i);
      if (mq[i].size() != 0) e_idle = 1'b0;
    end
    e_cmplt = 1'b0;
    e_iid   = '0;
    g       = -1;
    if (!f)
      for (int k = 0; k < 3; k++) begin
        idx = (mrr + k) % 3;
        if (g < 0 && (mq[idx].size() != 0 || (BYP && s[idx])))
          g = idx;
      end
    if (g >= 0) begin
      e_cmplt = 1'b1;
      e_iid = (mq[g].size() != 0) ? mq[g][0] : iin[g];
    end
    if (f) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      mrr = 0;
    end else begin
      for (int i = 0; i < 3; i++)
        acc[i] = s[i] && mrdy(i) && !(i == g && mq[i].size() == 0);
      if (g >= 0) begin
        if (mq[g].size() != 0) void'(mq[g].pop_front());
        mrr = (g + 1) % 3;
      end
      for (int i = 0; i < 3; i++)
        if (acc[i]) mq[i].push_back(iin[i]);
    end
  endtask

  task automatic step(input logic [2:0] s,
                      input logic [6:0] a, b, c,
                      input logic f);
    cfg_sel = s[0]; cfg_iid = a;
    alu_sel = s[1]; alu_iid = b;
    lsu_sel = s[2]; lsu_iid = c;
    flush   = f;
    @(negedge clk);
    model_eval(s, a, b, c, f);
    o_cmplt = cmplt; o_iid = iid; o_idle = idle;
    o_rdy = {lsu_rdy, alu_rdy, cfg_rdy};
    chk("model", {20'd0, o_cmplt, o_iid, o_rdy, o_idle},
                 {20'd0, e_cmplt, e_iid, e_rdy, e_idle});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    cfg_sel = 0; alu_sel = 0; lsu_sel = 0;
    cfg_iid = 0; alu_iid = 0; lsu_iid = 0;
    flush = 0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_in();
    for (int i = 0; i < 3; i++) mq[i].delete();
    mrr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {20'd0, cmplt, iid, lsu_rdy, alu_rdy,
                      cfg_rdy, idle}, 32'h00F);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         n;
    logic [6:0] got [4];
    int         prev;
    int         src;
    int         ncm;
    logic [2:0] s;

    do_reset();

    // Triple simultaneous completion and rr wrap.
`ifdef CT_MAT_CMPLT_BYPASS_EN
    vt[0] = mk(3'b000, 0, 0, 0,   0, 0,  3'b111, 1);
    vt[1] = mk(3'b111, 5, 9, 12,  1, 5,  3'b111, 1);
    vt[2] = mk(3'b000, 0, 0, 0,   1, 9,  3'b111, 0);
    vt[3] = mk(3'b000, 0, 0, 0,   1, 12, 3'b111, 0);
    vt[4] = mk(3'b000, 0, 0, 0,   0, 0,  3'b111, 1);
    vt[5] = mk(3'b000, 0, 0, 0,   0, 0,  3'b111, 1);
    vt[6] = mk(3'b101, 30, 0, 31, 1, 30, 3'b111, 1);
    vt[7] = mk(3'b000, 0, 0, 0,   1, 31, 3'b111, 0);
    vt[8] = mk(3'b000, 0, 0, 0,   0, 0,  3'b111, 1);
    vt[9] = mk(3'b000, 0, 0, 0,   0, 0,  3'b111, 1);
`else
    vt[0] = mk(3'b000, 0, 0, 0,   0, 0,  3'b111, 1);
    vt[1] = mk(3'b111, 5, 9, 12,  0, 0,  3'b111, 1);
    vt[2] = mk(3'b000, 0, 0, 0,   1, 5,  3'b111, 0);
    vt[3] = mk(3'b000, 0, 0, 0,   1, 9,  3'b111, 0);
    vt[4] = mk(3'b000, 0, 0, 0,   1, 12, 3'b111, 0);
    vt[5] = mk(3'b000, 0, 0, 0,   0, 0,  3'b111, 1);
    vt[6] = mk(3'b101, 30, 0, 31, 0, 0,  3'b111, 1);
    vt[7] = mk(3'b000, 0, 0, 0,   1, 30, 3'b111, 0);
    vt[8] = mk(3'b000, 0, 0, 0,   1, 31, 3'b111, 0);
    vt[9] = mk(3'b000, 0, 0, 0,   0, 0,  3'b111, 1);
`endif
    for (int r = 0; r < 10; r++) begin
      step(vt[r].sel, vt[r].i0, vt[r].i1, vt[r].i2, 1'b0);
      chk($sformatf("vec%0d", r),
          {20'd0, o_cmplt, o_iid, o_rdy, o_idle},
          {20'd0, vt[r].c, vt[r].id, vt[r].r, vt[r].idl});
    end

    // Full alu FIFO, dropped third sel, in-order retire.
    do_reset();
    n = 0;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: step(3'b011, 50, 1, 0, 0);
        1: step(3'b011, 51, 2, 0, 0);
        2: step(3'b010, 0, 3, 0, 0);
        default: step(3'b000, 0, 0, 0, 0);
      endcase
`ifndef CT_MAT_CMPLT_BYPASS_EN
      if (c == 2) chk("alu_full", {31'd0, o_rdy[1]}, 32'd0);
      if (c == 3) chk("alu_rdy_back", {31'd0, o_rdy[1]}, 32'd1);
`endif
      if (o_cmplt && o_iid < 7'd4 && n < 4) begin
        got[n] = o_iid;
        n++;
      end
    end
`ifndef CT_MAT_CMPLT_BYPASS_EN
    chk("alu_n", n, 2);
    chk("alu_first", {25'd0, got[0]}, 32'd1);
    chk("alu_second", {25'd0, got[1]}, 32'd2);
`endif

    // cfg and lsu continuously busy must alternate.
    do_reset();
    prev = -1;
    ncm  = 0;
    for (int c = 0; c < 12; c++) begin
      s = {mrdy(2) ? 1'b1 : 1'b0, 1'b0, mrdy(0) ? 1'b1 : 1'b0};
      step(s, 7'(16 + c), 0, 7'(48 + c), 0);
      if (o_cmplt) begin
        src = (o_iid >= 7'd48) ? 2 : (o_iid >= 7'd16 ? 0 : 1);
        if (prev >= 0) chk("rr_alt", src != prev, 1);
        chk("rr_src", src != 1, 1);
        prev = src;
        ncm++;
      end
    end
    chk("rr_busy", ncm >= 10, 1);

    // Flush with lsu holding two entries and a new sel.
    do_reset();
    step(3'b111, 60, 61, 41, 0);
    step(3'b100, 0, 0, 42, 0);
    step(3'b100, 0, 0, 40, 1);
    chk("flush_cmplt", {31'd0, o_cmplt}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      step(3'b000, 0, 0, 0, 0);
      if (c == 0) chk("flush_idle", {31'd0, o_idle}, 32'd1);
      chk("flush_quiet", {31'd0, o_cmplt}, 32'd0);
    end

    // Asynchronous reset between edges with entries queued.
    do_reset();
    step(3'b111, 70, 71, 72, 0);
    step(3'b111, 75, 73, 74, 0);
    idle_in();
    chk("pre_rst_q", (mq[0].size() + mq[1].size()
                      + mq[2].size()) >= 4, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {20'd0, cmplt, iid, lsu_rdy, alu_rdy,
                      cfg_rdy, idle}, 32'h00F);
    for (int i = 0; i < 3; i++) mq[i].delete();
    mrr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      step(3'b000, 0, 0, 0, 0);
      chk("post_rst_quiet", {31'd0, o_cmplt}, 32'd0);
    end

    // Random traffic, incl. protocol violations and flushes.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++)
        s[i] = ($urandom_range(3) != 0)
            && (mrdy(i) || $urandom_range(7) == 0);
      step(s, 7'($urandom), 7'($urandom), 7'($urandom),
           $urandom_range(31) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
